orion_icache: RTL and testbench

//  Direct-mapped, read-only instruction cache between the core fetch port and a word-wide backing memory.

---
 rtl/orion_types.sv | 25 ++
 rtl/orion_icache_if.sv | 42 ++++
 rtl/orion_icache_data.sv | 25 ++
 rtl/orion_icache.sv | 165 ++++++++++++++++
 tb/tb_orion_icache.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/orion_types.sv
// rtl/orion_types.sv - shared types and constants for the orion instruction cache
package orion_types;

    localparam int ICACHE_ADDRW      = 32;
    localparam int ICACHE_NUM_LINES  = 16;
    localparam int ICACHE_LINE_WORDS = 4;
    localparam int ICACHE_OFFB       = $clog2(ICACHE_LINE_WORDS);
    localparam int ICACHE_IDXB       = $clog2(ICACHE_NUM_LINES);
    localparam int ICACHE_TAGB       = ICACHE_ADDRW - ICACHE_IDXB - ICACHE_OFFB - 2;

    typedef enum logic [1:0] {
        IC_IDLE,
        IC_REFILL,
        IC_RESPOND
    } icache_state_e;

    // Field view of a fetch address for the default geometry
    typedef struct packed {
        logic [ICACHE_TAGB-1:0] tag;
        logic [ICACHE_IDXB-1:0] idx;
        logic [ICACHE_OFFB-1:0] off;
        logic [1:0]             byte_off;
    } icache_addr_t;

endpackage

// File: rtl/orion_icache_if.sv
// rtl/orion_icache_if.sv - fetch port, flush and backing-memory signals of the instruction cache
interface orion_icache_if #(
    parameter int ADDRW = 32,
    parameter int XLEN  = 32
);

    logic             imem_valid_i;
    logic [ADDRW-1:0] imem_addr_i;
    logic [XLEN-1:0]  imem_rdata_o;
    logic             imem_resp_o;
    logic             flush_i;
    logic             mem_valid_o;
    logic [ADDRW-1:0] mem_addr_o;
    logic [XLEN-1:0]  mem_rdata_i;
    logic             mem_resp_i;

    // slave is the cache itself; master is the core plus backing memory around it
    modport slave (
        input  imem_valid_i,
        input  imem_addr_i,
        input  flush_i,
        input  mem_rdata_i,
        input  mem_resp_i,
        output imem_rdata_o,
        output imem_resp_o,
        output mem_valid_o,
        output mem_addr_o
    );

    modport master (
        output imem_valid_i,
        output imem_addr_i,
        output flush_i,
        output mem_rdata_i,
        output mem_resp_i,
        input  imem_rdata_o,
        input  imem_resp_o,
        input  mem_valid_o,
        input  mem_addr_o
    );

endinterface

// File: rtl/orion_icache_data.sv
// rtl/orion_icache_data.sv - cache data store: flop array, one synchronous write port, one asynchronous read port
module orion_icache_data #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic            clk_i,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/orion_icache.sv
// rtl/orion_icache.sv - direct-mapped read-only instruction cache with whole-line sequential refill
module orion_icache
    import orion_types::*;
#(
    parameter int ADDRW      = 32,
    parameter int XLEN       = 32,
    parameter int NUM_LINES  = ICACHE_NUM_LINES,
    parameter int LINE_WORDS = ICACHE_LINE_WORDS
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    orion_icache_if.slave bus
);

    localparam int OFFB  = $clog2(LINE_WORDS);
    localparam int IDXB  = $clog2(NUM_LINES);
    localparam int TAGB  = ADDRW - IDXB - OFFB - 2;
    localparam int DEPTH = NUM_LINES * LINE_WORDS;
    localparam int DAW   = IDXB + OFFB;
    localparam logic [OFFB-1:0] LAST_CNT = OFFB'(LINE_WORDS - 1);

    icache_state_e state, state_next;

    logic [NUM_LINES-1:0] valid;
    logic [TAGB-1:0]      tags [NUM_LINES];

    logic [TAGB-1:0] tag_q;
    logic [IDXB-1:0] idx_q;
    logic [OFFB-1:0] off_q;
    logic [OFFB-1:0] cnt;
    logic            flush_pend;
    logic            resp_q;
    logic [XLEN-1:0] rdata_q;

    logic [TAGB-1:0] req_tag;
    logic [IDXB-1:0] req_idx;
    logic [OFFB-1:0] req_off;
    logic            unused_byte_bits;

    logic            lookup;
    logic            hit;
    logic            miss;
    logic            refill_we;
    logic            refill_last;
    logic [IDXB-1:0] rd_idx;
    logic [OFFB-1:0] rd_off;
    logic [XLEN-1:0] rd_data;

    assign req_tag          = bus.imem_addr_i[ADDRW-1 -: TAGB];
    assign req_idx          = bus.imem_addr_i[OFFB+2 +: IDXB];
    assign req_off          = bus.imem_addr_i[2 +: OFFB];
    assign unused_byte_bits = ^bus.imem_addr_i[1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IC_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A response cycle never looks up, so the core sees at most one answer per two cycles
    always_comb begin
        state_next  = state;
        lookup      = 1'b0;
        hit         = 1'b0;
        miss        = 1'b0;
        refill_we   = 1'b0;
        refill_last = 1'b0;
        case (state)
            IC_IDLE: begin
                lookup = bus.imem_valid_i && !resp_q;
                hit    = lookup && valid[req_idx] && (tags[req_idx] == req_tag) && !bus.flush_i;
                miss   = lookup && !hit;
                if (miss) begin
                    state_next = IC_REFILL;
                end
            end
            IC_REFILL: begin
                refill_we   = bus.mem_resp_i;
                refill_last = bus.mem_resp_i && (cnt == LAST_CNT);
                if (refill_last) begin
                    state_next = IC_RESPOND;
                end
            end
            IC_RESPOND: begin
                state_next = IC_IDLE;
            end
            default: begin
                state_next = IC_IDLE;
            end
        endcase
    end

    assign rd_idx = (state == IC_IDLE) ? req_idx : idx_q;
    assign rd_off = (state == IC_IDLE) ? req_off : off_q;

    orion_icache_data #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .AW    (DAW)
    ) u_data (
        .clk_i (clk_i),
        .we    (refill_we),
        .waddr ({idx_q, cnt}),
        .wdata (bus.mem_rdata_i),
        .raddr ({rd_idx, rd_off}),
        .rdata (rd_data)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid      <= '0;
            tag_q      <= '0;
            idx_q      <= '0;
            off_q      <= '0;
            cnt        <= '0;
            flush_pend <= 1'b0;
            resp_q     <= 1'b0;
            rdata_q    <= '0;
        end else begin
            resp_q <= 1'b0;
            if (hit) begin
                resp_q  <= 1'b1;
                rdata_q <= rd_data;
            end
            if (miss) begin
                tag_q <= req_tag;
                idx_q <= req_idx;
                off_q <= req_off;
                cnt   <= '0;
            end
            if (refill_we) begin
                cnt <= cnt + 1'b1;
            end
            if (state == IC_REFILL && bus.flush_i) begin
                flush_pend <= 1'b1;
            end
            if (state == IC_RESPOND) begin
                resp_q     <= 1'b1;
                rdata_q    <= rd_data;
                flush_pend <= 1'b0;
            end
            // A flush seen during the refill keeps the freshly filled line invalid
            if (refill_last && !flush_pend) begin
                valid[idx_q] <= 1'b1;
            end
            if (bus.flush_i) begin
                valid <= '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (refill_last) begin
            tags[idx_q] <= tag_q;
        end
    end

    assign bus.imem_resp_o  = resp_q;
    assign bus.imem_rdata_o = rdata_q;
    assign bus.mem_valid_o  = (state == IC_REFILL);
    assign bus.mem_addr_o   = (state == IC_REFILL) ? {tag_q, idx_q, cnt, 2'b00} : '0;

endmodule

// File: tb/tb_orion_icache.sv
// tb/tb_orion_icache.sv - directed and randomized checks of orion_icache against a line-presence model
module tb_orion_icache;
    import orion_types::*;

    logic clk_i = 1'b0;
    logic rst_ni;

    always #5 clk_i = ~clk_i;

    orion_icache_if #(.ADDRW(32), .XLEN(32)) bus ();

    orion_icache #(
        .ADDRW      (32),
        .XLEN       (32),
        .NUM_LINES  (ICACHE_NUM_LINES),
        .LINE_WORDS (ICACHE_LINE_WORDS)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    int total  = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Backing memory with programmable wait states; can also raise flush on the Nth refill word
    int          wait_cycles   = 0;
    int          flush_at_word = 0;
    bit          flush_req     = 1'b0;
    int          wcnt          = 0;
    int          resp_num      = 0;
    bit          fire;
    logic [31:0] hold_addr;
    logic [31:0] mem_log [$];

    always @(negedge clk_i) begin
        fire           = 1'b0;
        bus.mem_resp_i = 1'b0;
        if (bus.mem_valid_o === 1'b1) begin
            if (wcnt > 0) check("mem_addr_hold", bus.mem_addr_o, hold_addr);
            hold_addr = bus.mem_addr_o;
            if (wcnt >= wait_cycles) begin
                bus.mem_resp_i  = 1'b1;
                bus.mem_rdata_i = mem_word(bus.mem_addr_o);
                mem_log.push_back(bus.mem_addr_o);
                resp_num++;
                wcnt = 0;
                if (resp_num == flush_at_word) begin
                    fire          = 1'b1;
                    flush_at_word = 0;
                end
            end else begin
                wcnt++;
            end
        end else begin
            wcnt     = 0;
            resp_num = 0;
        end
        bus.flush_i = flush_req || fire;
        flush_req   = 1'b0;
    end

    // Reference model: which tag each line currently holds
    bit                     m_valid [ICACHE_NUM_LINES];
    logic [ICACHE_TAGB-1:0] m_tag   [ICACHE_NUM_LINES];

    task automatic model_clear();
        for (int i = 0; i < ICACHE_NUM_LINES; i++) m_valid[i] = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] addr, input int fw, input string tag);
        icache_addr_t a;
        bit           exp_hit;
        bit           done;
        int           lat;
        int           exp_lat;
        logic [31:0]  got;
        logic [31:0]  ea;
        a       = addr;
        exp_hit = m_valid[a.idx] && (m_tag[a.idx] == a.tag);
        exp_lat = exp_hit ? 1 : ICACHE_LINE_WORDS * (wait_cycles + 1) + 2;
        mem_log.delete();
        flush_at_word = exp_hit ? 0 : fw;
        @(negedge clk_i);
        while (bus.imem_resp_o === 1'b1) @(negedge clk_i);
        bus.imem_valid_i = 1'b1;
        bus.imem_addr_i  = addr;
        lat  = 0;
        done = 1'b0;
        got  = '0;
        while (!done && lat < 200) begin
            @(posedge clk_i);
            #1;
            lat++;
            if (bus.imem_resp_o === 1'b1) begin
                done = 1'b1;
                got  = bus.imem_rdata_o;
            end
        end
        bus.imem_valid_i = 1'b0;
        flush_at_word    = 0;
        check({tag, "_resp"}, 32'(done), 32'd1);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_data"}, got, mem_word(addr));
        check({tag, "_nreads"}, mem_log.size(), exp_hit ? 0 : ICACHE_LINE_WORDS);
        for (int k = 0; k < mem_log.size() && k < ICACHE_LINE_WORDS; k++) begin
            ea = {addr[31:4], 4'h0} + 32'(k * 4);
            check({tag, "_maddr"}, mem_log[k], ea);
        end
        if (!exp_hit) begin
            if (fw != 0) model_clear();
            m_valid[a.idx] = (fw == 0);
            m_tag[a.idx]   = a.tag;
        end
    endtask

    task automatic do_flush();
        @(posedge clk_i);
        #1 flush_req = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        model_clear();
    endtask

    initial begin
        logic [31:0] ra;
        int          fw;
        bus.imem_valid_i = 1'b0;
        bus.imem_addr_i  = '0;
        rst_ni           = 1'b0;
        model_clear();
        repeat (2) @(negedge clk_i);
        check("rst_imem_resp", 32'(bus.imem_resp_o), 32'd0);
        check("rst_imem_rdata", bus.imem_rdata_o, 32'd0);
        check("rst_mem_valid", 32'(bus.mem_valid_o), 32'd0);
        check("rst_mem_addr", bus.mem_addr_o, 32'd0);
        rst_ni = 1'b1;

        fetch(32'h8000_0004, 0, "cold");
        fetch(32'h8000_0008, 0, "hit");
        fetch(32'h8000_000C, 0, "hit_b2b");
        fetch(32'h8000_0100, 0, "conflict");
        fetch(32'h8000_0000, 0, "evicted");

        wait_cycles = 3;
        fetch(32'h8000_0040, 0, "wait3");
        wait_cycles = 0;

        do_flush();
        fetch(32'h8000_0008, 0, "post_flush");
        fetch(32'h8000_0200, 2, "flush_mid");
        fetch(32'h8000_0204, 0, "after_mid");

        @(negedge clk_i);
        while (bus.imem_resp_o === 1'b1) @(negedge clk_i);
        bus.imem_valid_i = 1'b1;
        bus.imem_addr_i  = 32'h8000_0004;
        repeat (3) @(posedge clk_i);
        #2;
        check("pre_rst_mem_valid", 32'(bus.mem_valid_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        check("async_rst_mem_valid", 32'(bus.mem_valid_o), 32'd0);
        check("async_rst_imem_resp", 32'(bus.imem_resp_o), 32'd0);
        check("async_rst_mem_addr", bus.mem_addr_o, 32'd0);
        bus.imem_valid_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_clear();
        fetch(32'h8000_0004, 0, "post_rst");

        repeat (40) begin
            ra = 32'h8000_0000 | (32'($urandom_range(0, 2)) << 8)
                               | (32'($urandom_range(0, 3)) << 4)
                               | (32'($urandom_range(0, 3)) << 2);
            wait_cycles = $urandom_range(0, 2);
            fw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0;
            if ($urandom_range(0, 9) == 0) do_flush();
            fetch(ra, fw, "rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
